// File: rtl/ui_input_device_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ui_input_device_pkg
// Description : Register map encodings, control-register bit positions and
//               control-state helpers for the push-button / switch device.
//               Shared with the IO controller.
// Revision    : 1.0 - initial release
// ============================================================================
package ui_input_device_pkg;

    // Register select encodings
    localparam logic [1:0] c_REG_KDATA = 2'd0;
    localparam logic [1:0] c_REG_KCTRL = 2'd1;
    localparam logic [1:0] c_REG_SDATA = 2'd2;
    localparam logic [1:0] c_REG_SCTRL = 2'd3;

    // Control register bit positions
    localparam int c_CTRL_READY_BIT   = 0;
    localparam int c_CTRL_OVERRUN_BIT = 2;
    localparam int c_CTRL_IE_BIT      = 8;
    localparam int c_CTRL_WIDTH       = 9;

    // Per-group control/status state
    typedef struct packed {
        logic ie;
        logic overrun;
        logic ready;
    } ctrlState_t;

    // Control register image; unused bits read as zero
    function automatic logic [c_CTRL_WIDTH-1:0] packCtrl(input ctrlState_t s);
        logic [c_CTRL_WIDTH-1:0] v;
        v                     = '0;
        v[c_CTRL_READY_BIT]   = s.ready;
        v[c_CTRL_OVERRUN_BIT] = s.overrun;
        v[c_CTRL_IE_BIT]      = s.ie;
        return v;
    endfunction

    // Next control state for one group.
    // A change event always wins over a data read (READY stays set and the
    // event is not an overrun because the old value was consumed), and a
    // newly detected overrun wins over a software clear in the same cycle.
    function automatic ctrlState_t nextCtrl(
        input ctrlState_t                cur,
        input logic                      changeEvt,
        input logic                      dataRead,
        input logic                      ctrlWrite,
        input logic [c_CTRL_WIDTH-1:0]   wrData
    );
        ctrlState_t n;
        n = cur;
        if (changeEvt) begin
            n.ready = 1'b1;
        end else if (dataRead) begin
            n.ready = 1'b0;
        end
        if (changeEvt && cur.ready && !dataRead) begin
            n.overrun = 1'b1;
        end else if (ctrlWrite && !wrData[c_CTRL_OVERRUN_BIT]) begin
            n.overrun = 1'b0;
        end
        if (ctrlWrite) begin
            n.ie = wrData[c_CTRL_IE_BIT];
        end
        return n;
    endfunction

endpackage : ui_input_device_pkg
`default_nettype wire

// File: rtl/ui_input_device_debouncer.sv
`default_nettype none
// ============================================================================
// Module      : input_debouncer
// Description : 2-flop synchronizer followed by a stability counter. A new
//               value is accepted once the synchronized input has disagreed
//               with the accepted value for DEBOUNCE_CYCLES consecutive
//               cycles; o_change pulses in the cycle the value is accepted.
// Revision    : 1.0 - initial release
// ============================================================================
module input_debouncer #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 100000,
    parameter bit ACTIVE_LOW      = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_raw,
    output logic [WIDTH-1:0] o_stable,
    output logic             o_change
);

    localparam int                 c_CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);
    // Active-low inputs reset to their released level so no spurious edge
    // is seen after reset.
    localparam logic [WIDTH-1:0]   c_SYNC_RST = {WIDTH{ACTIVE_LOW}};

    logic [WIDTH-1:0]   r_sync1;
    logic [WIDTH-1:0]   r_sync2;
    logic [WIDTH-1:0]   r_stable;
    logic [c_CNT_W-1:0] r_count;
    logic [WIDTH-1:0]   w_synced;
    logic               w_differ;
    logic               w_load;

    // Normalise polarity after synchronization so 1 always means active
    assign w_synced = r_sync2 ^ {WIDTH{ACTIVE_LOW}};
    assign w_differ = (w_synced != r_stable);
    assign w_load   = w_differ && (r_count == c_CNT_LAST);

    // Two-flop synchronizer for the asynchronous raw inputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= c_SYNC_RST;
            r_sync2 <= c_SYNC_RST;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Stability counter: any return to the accepted value restarts the count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stable <= '0;
            r_count  <= '0;
        end else if (!w_differ) begin
            r_count <= '0;
        end else if (w_load) begin
            r_stable <= w_synced;
            r_count  <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_stable = r_stable;
    assign o_change = w_load;

endmodule : input_debouncer
`default_nettype wire

// File: rtl/ui_input_device.sv
`default_nettype none
// ============================================================================
// Module      : ui_input_device
// Description : Memory-mapped push-button (KEY) and slide-switch (SW) input
//               device with debouncing, READY/OVERRUN status, per-group
//               interrupt enable and a registered interrupt request.
// Revision    : 1.0 - initial release
// ============================================================================
module ui_input_device
    import ui_input_device_pkg::*;
#(
    parameter int DBITS           = 32,
    parameter int KEY_BITS        = 4,
    parameter int SW_BITS         = 10,
    parameter int DEBOUNCE_CYCLES = 100000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [KEY_BITS-1:0] KEY,
    input  logic [SW_BITS-1:0]  SW,
    input  logic                rdEn,
    input  logic                wrtEn,
    input  logic [1:0]          regSel,
    input  logic [DBITS-1:0]    dataIn,
    output logic [DBITS-1:0]    dataOut,
    output logic                irq
);

    logic [KEY_BITS-1:0] w_keyStable;
    logic [SW_BITS-1:0]  w_swStable;
    logic                w_keyChange;
    logic                w_swChange;
    logic                w_keyDataRead;
    logic                w_swDataRead;
    logic                w_keyCtrlWrite;
    logic                w_swCtrlWrite;
    ctrlState_t          r_keyCtrl;
    ctrlState_t          r_swCtrl;
    logic                r_irq;

    input_debouncer #(
        .WIDTH           (KEY_BITS),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .ACTIVE_LOW      (1'b1)
    ) u_keyDebounce (
        .clk      (clk),
        .rst      (reset),
        .i_raw    (KEY),
        .o_stable (w_keyStable),
        .o_change (w_keyChange)
    );

    input_debouncer #(
        .WIDTH           (SW_BITS),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .ACTIVE_LOW      (1'b0)
    ) u_swDebounce (
        .clk      (clk),
        .rst      (reset),
        .i_raw    (SW),
        .o_stable (w_swStable),
        .o_change (w_swChange)
    );

    assign w_keyDataRead  = rdEn  && (regSel == c_REG_KDATA);
    assign w_swDataRead   = rdEn  && (regSel == c_REG_SDATA);
    assign w_keyCtrlWrite = wrtEn && (regSel == c_REG_KCTRL);
    assign w_swCtrlWrite  = wrtEn && (regSel == c_REG_SCTRL);

    // Status/enable bits of both groups; data registers ignore writes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_keyCtrl <= '0;
            r_swCtrl  <= '0;
        end else begin
            r_keyCtrl <= nextCtrl(r_keyCtrl, w_keyChange, w_keyDataRead,
                                  w_keyCtrlWrite, dataIn[c_CTRL_WIDTH-1:0]);
            r_swCtrl  <= nextCtrl(r_swCtrl, w_swChange, w_swDataRead,
                                  w_swCtrlWrite, dataIn[c_CTRL_WIDTH-1:0]);
        end
    end

    // Interrupt request registered from the current status, one cycle behind
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= (r_keyCtrl.ready && r_keyCtrl.ie) ||
                     (r_swCtrl.ready  && r_swCtrl.ie);
        end
    end

    assign irq = r_irq;

    // Read mux: purely a function of regSel and state, no dependence on rdEn
    always_comb begin
        dataOut = '0;
        case (regSel)
            c_REG_KDATA: dataOut[KEY_BITS-1:0]     = w_keyStable;
            c_REG_KCTRL: dataOut[c_CTRL_WIDTH-1:0] = packCtrl(r_keyCtrl);
            c_REG_SDATA: dataOut[SW_BITS-1:0]      = w_swStable;
            default:     dataOut[c_CTRL_WIDTH-1:0] = packCtrl(r_swCtrl);
        endcase
    end

endmodule : ui_input_device
`default_nettype wire

// File: tb/tb_ui_input_device.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_ui_input_device
// Description : Self-checking bench for ui_input_device: directed scenarios
//               followed by randomized traffic against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ui_input_device;
    import ui_input_device_pkg::*;

    localparam int DBITS    = 32;
    localparam int KEY_BITS = 4;
    localparam int SW_BITS  = 10;
    localparam int DEB      = 4;

    logic                clk = 1'b0;
    logic                reset;
    logic [KEY_BITS-1:0] KEY;
    logic [SW_BITS-1:0]  SW;
    logic                rdEn;
    logic                wrtEn;
    logic [1:0]          regSel;
    logic [DBITS-1:0]    dataIn;
    logic [DBITS-1:0]    dataOut;
    logic                irq;

    int nChecks = 0;
    int nErrors = 0;

    ui_input_device #(
        .DBITS           (DBITS),
        .KEY_BITS        (KEY_BITS),
        .SW_BITS         (SW_BITS),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .KEY     (KEY),
        .SW      (SW),
        .rdEn    (rdEn),
        .wrtEn   (wrtEn),
        .regSel  (regSel),
        .dataIn  (dataIn),
        .dataOut (dataOut),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    // Single comparison point for the whole bench
    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nErrors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic peek(input logic [1:0] sel, input string tag, input logic [31:0] exp);
        regSel = sel;
        #1;
        checkVal(tag, dataOut, exp);
    endtask

    // ---------------- behavioural reference model (group 0 = KEY, 1 = SW)
    // Values are held in "active = 1" form; the raw input passes through a
    // two-cycle delay, and a new value is accepted once the delayed input
    // has disagreed with the accepted one for DEB consecutive cycles.
    logic [9:0] mPre[2];
    logic [9:0] mSync[2];
    logic [9:0] mStable[2];
    int         mRun[2];
    logic       mReady[2];
    logic       mOvr[2];
    logic       mIe[2];
    logic       mIrq;

    task automatic modelReset();
        for (int g = 0; g < 2; g++) begin
            mPre[g] = '0; mSync[g] = '0; mStable[g] = '0; mRun[g] = 0;
            mReady[g] = 1'b0; mOvr[g] = 1'b0; mIe[g] = 1'b0;
        end
        mIrq = 1'b0;
    endtask

    task automatic modelEdge(input logic [9:0] rawK, input logic [9:0] rawS,
                             input logic rd, input logic wr,
                             input logic [1:0] sel, input logic [31:0] din);
        logic [9:0] raw[2];
        logic       evt;
        logic       dataRd;
        logic       ctrlWr;
        raw[0] = rawK;
        raw[1] = rawS;
        mIrq = (mReady[0] && mIe[0]) || (mReady[1] && mIe[1]);
        for (int g = 0; g < 2; g++) begin
            evt = 1'b0;
            if (mSync[g] != mStable[g]) begin
                mRun[g]++;
                if (mRun[g] == DEB) begin
                    mStable[g] = mSync[g];
                    mRun[g]    = 0;
                    evt        = 1'b1;
                end
            end else begin
                mRun[g] = 0;
            end
            mSync[g] = mPre[g];
            mPre[g]  = raw[g];
            dataRd = rd && (sel == ((g == 0) ? 2'd0 : 2'd2));
            ctrlWr = wr && (sel == ((g == 0) ? 2'd1 : 2'd3));
            if (evt && mReady[g] && !dataRd) mOvr[g] = 1'b1;
            else if (ctrlWr && !din[2])      mOvr[g] = 1'b0;
            if (evt)         mReady[g] = 1'b1;
            else if (dataRd) mReady[g] = 1'b0;
            if (ctrlWr) mIe[g] = din[8];
        end
    endtask

    function automatic logic [31:0] expRead(input logic [1:0] sel);
        logic [31:0] v;
        int          g;
        v = '0;
        g = sel[1];
        if (sel[0] == 1'b0) begin
            v[9:0] = mStable[g];
        end else begin
            v[0] = mReady[g];
            v[2] = mOvr[g];
            v[8] = mIe[g];
        end
        return v;
    endfunction

    // Hard bound on total run time
    initial begin
        #500us;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", nChecks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int holdK;
        int holdS;
        reset = 1'b1; KEY = 4'hF; SW = '0; rdEn = 1'b0; wrtEn = 1'b0;
        regSel = c_REG_KDATA; dataIn = '0;
        repeat (3) tick();
        reset = 1'b0;

        // Reset state
        peek(c_REG_KDATA, "rst_kdata", 32'h0);
        peek(c_REG_KCTRL, "rst_kctrl", 32'h0);
        peek(c_REG_SDATA, "rst_sdata", 32'h0);
        peek(c_REG_SCTRL, "rst_sctrl", 32'h0);
        checkVal("rst_irq", {31'b0, irq}, 32'h0);

        // Clean press of KEY[0]: accepted exactly 6 cycles later
        KEY = 4'b1110;
        repeat (5) tick();
        peek(c_REG_KDATA, "press_kdata_cycle5", 32'h0);
        tick();
        peek(c_REG_KDATA, "press_kdata_cycle6", 32'h1);
        peek(c_REG_KCTRL, "press_kctrl_cycle6", 32'h1);
        regSel = c_REG_KDATA; rdEn = 1'b1;
        tick();
        rdEn = 1'b0;
        peek(c_REG_KCTRL, "read_clears_ready", 32'h0);

        // 2-cycle bounce on SW never reaches the accepted value
        regSel = c_REG_SCTRL;
        for (int i = 0; i < 12; i++) begin
            if (i == 0) SW = 10'h3FF;
            if (i == 2) SW = 10'h000;
            tick();
            peek(c_REG_SCTRL, "bounce_sctrl", 32'h0);
        end
        peek(c_REG_SDATA, "bounce_sdata", 32'h0);

        // Two changes without a read -> overrun; write 0 clears overrun only
        SW = 10'h001;
        repeat (6) tick();
        peek(c_REG_SCTRL, "sw_first_ready", 32'h001);
        SW = 10'h003;
        repeat (6) tick();
        peek(c_REG_SCTRL, "sw_overrun", 32'h005);
        peek(c_REG_SDATA, "sw_data_3", 32'h003);
        regSel = c_REG_SCTRL; dataIn = 32'h0; wrtEn = 1'b1;
        tick();
        wrtEn = 1'b0;
        peek(c_REG_SCTRL, "sw_ovr_cleared", 32'h001);
        regSel = c_REG_SDATA; rdEn = 1'b1;
        tick();
        rdEn = 1'b0;
        peek(c_REG_SCTRL, "sw_read_clears", 32'h000);

        // Interrupt enable: irq follows READY one cycle later
        regSel = c_REG_KCTRL; dataIn = 32'h100; wrtEn = 1'b1;
        tick();
        wrtEn = 1'b0; dataIn = '0;
        peek(c_REG_KCTRL, "ie_written", 32'h100);
        checkVal("irq_idle", {31'b0, irq}, 32'h0);
        KEY = 4'b1100;
        repeat (6) tick();
        peek(c_REG_KCTRL, "ie_ready", 32'h101);
        checkVal("irq_lags_ready", {31'b0, irq}, 32'h0);
        tick();
        checkVal("irq_rises", {31'b0, irq}, 32'h1);
        peek(c_REG_KDATA, "kdata_3", 32'h3);
        rdEn = 1'b1;
        tick();
        rdEn = 1'b0;
        peek(c_REG_KCTRL, "ie_read_clears", 32'h100);
        checkVal("irq_still_high", {31'b0, irq}, 32'h1);
        tick();
        checkVal("irq_falls", {31'b0, irq}, 32'h0);

        // Read coinciding with a change event: READY kept, no overrun
        KEY = 4'b1110;
        repeat (6) tick();
        peek(c_REG_KCTRL, "pre_coincide_ready", 32'h101);
        KEY = 4'b1010;
        repeat (5) tick();
        regSel = c_REG_KDATA; rdEn = 1'b1;
        tick();
        rdEn = 1'b0;
        peek(c_REG_KDATA, "coincide_kdata", 32'h5);
        peek(c_REG_KCTRL, "coincide_kctrl", 32'h101);
        regSel = c_REG_KCTRL; dataIn = '0; wrtEn = 1'b1;
        tick();
        wrtEn = 1'b0;

        // Reset in the middle of a debounce
        KEY = 4'hF; SW = 10'h001;
        repeat (2) tick();
        reset = 1'b1;
        #1;
        peek(c_REG_KDATA, "midrst_kdata", 32'h0);
        peek(c_REG_KCTRL, "midrst_kctrl", 32'h0);
        peek(c_REG_SDATA, "midrst_sdata", 32'h0);
        peek(c_REG_SCTRL, "midrst_sctrl", 32'h0);
        checkVal("midrst_irq", {31'b0, irq}, 32'h0);
        repeat (2) tick();
        reset = 1'b0;
        repeat (5) tick();
        peek(c_REG_SDATA, "postrst_sdata_cycle5", 32'h0);
        tick();
        peek(c_REG_SDATA, "postrst_sdata_cycle6", 32'h1);
        peek(c_REG_SCTRL, "postrst_sctrl_cycle6", 32'h1);
        peek(c_REG_KCTRL, "postrst_kctrl", 32'h0);

        // Randomized traffic against the reference model
        reset = 1'b1; KEY = 4'hF; SW = '0; rdEn = 1'b0; wrtEn = 1'b0; dataIn = '0;
        repeat (2) tick();
        reset = 1'b0;
        modelReset();
        holdK = 0;
        holdS = 0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            if (holdK == 0) begin
                KEY   = 4'($urandom);
                holdK = ($urandom_range(0, 1) == 0) ? int'($urandom_range(1, 3))
                                                    : int'($urandom_range(4, 12));
            end
            if (holdS == 0) begin
                SW    = 10'($urandom);
                holdS = ($urandom_range(0, 1) == 0) ? int'($urandom_range(1, 3))
                                                    : int'($urandom_range(4, 12));
            end
            holdK--;
            holdS--;
            rdEn   = ($urandom_range(0, 3) == 0);
            wrtEn  = ($urandom_range(0, 5) == 0);
            regSel = 2'($urandom);
            dataIn = $urandom;
            #1;
            checkVal("rand_dataOut", dataOut, expRead(regSel));
            checkVal("rand_irq", {31'b0, irq}, {31'b0, mIrq});
            @(posedge clk);
            modelEdge({6'b0, ~KEY}, SW, rdEn, wrtEn, regSel, dataIn);
            #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule : tb_ui_input_device
`default_nettype wire
